// File: rtl/cpu_gregs_banked_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_gregs_banked_pkg
// Purpose : Shared sizing constants for the banked integer register file and
//           the clog2 helper used to derive index/depth widths.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package cpu_gregs_banked_pkg;

  localparam int CPU_XLEN          = 32;
  localparam int CPU_GREG_COUNT    = 32;
  localparam int CPU_GREGIDX_WIDTH = 5;
  localparam int CPU_GREG_BANKS    = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int CPU_GREG_DEPTH_W = clog2(CPU_GREG_BANKS + 1);

endpackage
`default_nettype wire

// File: rtl/cpu_gregs_banked_if.sv
`default_nettype none
// ============================================================================
// Module  : cpu_gregs_banked_if
// Purpose : Bundles the read/write/stack/debug signals of the register file.
// Ports   : slave  - register file side (indices/controls in, data/status out)
//           master - core side (decode, writeback, trap controller, debug)
// Rev     : 1.0  initial release
// ============================================================================
interface cpu_gregs_banked_if #(
  parameter int XLEN    = 32,
  parameter int IDX_W   = 5,
  parameter int DEPTH_W = 2
);
  logic [IDX_W-1:0]   rs1_idx;
  logic [IDX_W-1:0]   rs2_idx;
  logic [XLEN-1:0]    rs1_dat;
  logic [XLEN-1:0]    rs2_dat;
  logic               rd_wen;
  logic [IDX_W-1:0]   rd_idx;
  logic [XLEN-1:0]    rd_dat;
  logic               backup;
  logic               restore;
  logic [DEPTH_W-1:0] depth;
  logic               full;
  logic               empty;
  logic               stk_err;
  logic               err_clr;
  logic [IDX_W-1:0]   dbg_idx;
  logic [XLEN-1:0]    dbg_dat;

  modport slave (
    input  rs1_idx, rs2_idx, rd_wen, rd_idx, rd_dat,
    input  backup, restore, err_clr, dbg_idx,
    output rs1_dat, rs2_dat, depth, full, empty, stk_err, dbg_dat
  );

  modport master (
    output rs1_idx, rs2_idx, rd_wen, rd_idx, rd_dat,
    output backup, restore, err_clr, dbg_idx,
    input  rs1_dat, rs2_dat, depth, full, empty, stk_err, dbg_dat
  );
endinterface
`default_nettype wire

// File: rtl/cpu_gregs_banked_stack_ctl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_gregs_stack_ctl
// Purpose : Shadow-stack bookkeeping: depth counter, full/empty, push/pop
//           decode with error detection, sticky error flag.
// Ports   : clk, reset_n          - clock, async active-low reset
//           backup_i, restore_i   - push / pop requests
//           err_clr_i             - clears the sticky error
//           push_en_o, pop_en_o   - accepted push / pop this cycle
//           bank_sel_o            - bank to write (push) or read (pop)
//           depth_o, full_o, empty_o, stk_err_o - status
// Rev     : 1.0  initial release
// ============================================================================
module cpu_gregs_stack_ctl #(
  parameter int BANKS   = 2,
  parameter int DEPTH_W = 2,
  parameter int SEL_W   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               backup_i,
  input  logic               restore_i,
  input  logic               err_clr_i,
  output logic               push_en_o,
  output logic               pop_en_o,
  output logic [SEL_W-1:0]   bank_sel_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               stk_err_o
);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               stk_err_q, stk_err_d;
  logic               full, empty, push, pop, err;

  always_comb begin
    full  = (depth_q == DEPTH_W'(BANKS));
    empty = (depth_q == '0);
    push  = backup_i & ~restore_i & ~full;
    pop   = restore_i & ~backup_i & ~empty;
    // Any request that was not accepted is an error, including simultaneous
    // backup+restore.
    err   = (backup_i | restore_i) & ~push & ~pop;

    depth_d = depth_q;
    if (push)     depth_d = depth_q + DEPTH_W'(1);
    else if (pop) depth_d = depth_q - DEPTH_W'(1);

    // Push writes bank[depth]; pop reads the top-of-stack bank[depth-1].
    bank_sel_o = pop ? SEL_W'(depth_q - DEPTH_W'(1)) : SEL_W'(depth_q);

    // Set wins over a same-cycle clear.
    stk_err_d = err ? 1'b1 : (err_clr_i ? 1'b0 : stk_err_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q   <= '0;
      stk_err_q <= 1'b0;
    end else begin
      depth_q   <= depth_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign push_en_o = push;
  assign pop_en_o  = pop;
  assign depth_o   = depth_q;
  assign full_o    = full;
  assign empty_o   = empty;
  assign stk_err_o = stk_err_q;

endmodule
`default_nettype wire

// File: rtl/cpu_gregs_banked.sv
`default_nettype none
// ============================================================================
// Module  : cpu_gregs_banked
// Purpose : Integer register file, 2 registered read ports with write-first
//           bypass, 1 write port, x0 hardwired to zero, combinational debug
//           read, and a shadow-bank stack for trap context save/restore.
// Ports   : clk, reset_n - clock, async active-low reset
//           bus (slave)  - read/write ports, backup/restore, status, debug
// Rev     : 1.0  initial release
// ============================================================================
module cpu_gregs_banked
  import cpu_gregs_banked_pkg::*;
#(
  parameter int XLEN      = CPU_XLEN,
  parameter int REG_COUNT = CPU_GREG_COUNT,
  parameter int IDX_W     = CPU_GREGIDX_WIDTH,
  parameter int BANKS     = CPU_GREG_BANKS,
  parameter int DEPTH_W   = CPU_GREG_DEPTH_W
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_gregs_banked_if.slave bus
);

  localparam int SEL_W = (BANKS > 1) ? clog2(BANKS) : 1;

  logic [XLEN-1:0]  regs_q   [REG_COUNT];
  logic [XLEN-1:0]  shadow_q [BANKS][REG_COUNT];
  logic [XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic             push_en, pop_en;
  logic [SEL_W-1:0] bank_sel;

  cpu_gregs_stack_ctl #(
    .BANKS   (BANKS),
    .DEPTH_W (DEPTH_W),
    .SEL_W   (SEL_W)
  ) u_stack_ctl (
    .clk        (clk),
    .reset_n    (reset_n),
    .backup_i   (bus.backup),
    .restore_i  (bus.restore),
    .err_clr_i  (bus.err_clr),
    .push_en_o  (push_en),
    .pop_en_o   (pop_en),
    .bank_sel_o (bank_sel),
    .depth_o    (bus.depth),
    .full_o     (bus.full),
    .empty_o    (bus.empty),
    .stk_err_o  (bus.stk_err)
  );

  // Read data: held on an accepted restore, otherwise live value with
  // write-first bypass (never for x0).
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (!pop_en) begin
      if (bus.rs1_idx == '0)
        rs1_d = '0;
      else if (bus.rd_wen && (bus.rd_idx == bus.rs1_idx))
        rs1_d = bus.rd_dat;
      else
        rs1_d = regs_q[bus.rs1_idx];

      if (bus.rs2_idx == '0)
        rs2_d = '0;
      else if (bus.rd_wen && (bus.rd_idx == bus.rs2_idx))
        rs2_d = bus.rd_dat;
      else
        rs2_d = regs_q[bus.rs2_idx];
    end
  end

  // Live file: a restore overwrites everything and discards the write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      regs_q[0] <= '0;
      for (int i = 1; i < REG_COUNT; i++) begin
        if (pop_en)
          regs_q[i] <= shadow_q[bank_sel][i];
        else if (bus.rd_wen && (bus.rd_idx == IDX_W'(i)))
          regs_q[i] <= bus.rd_dat;
      end
    end
  end

  // Shadow banks are not reset. The snapshot takes the pre-write file since
  // regs_q is sampled before this edge's update.
  always_ff @(posedge clk) begin
    if (push_en && reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) shadow_q[bank_sel][i] <= regs_q[i];
    end
  end

  assign bus.rs1_dat = rs1_q;
  assign bus.rs2_dat = rs2_q;
  assign bus.dbg_dat = (bus.dbg_idx == '0) ? '0 : regs_q[bus.dbg_idx];

endmodule
`default_nettype wire
